// File: rtl/pattern_scheduler.sv
// Timestamped pattern FIFO: presents each entry's pattern while the game
// counter matches its timestamp, then retires it; stale entries are counted.
module pattern_scheduler #(
    parameter int         DEPTH = 16,
    parameter logic [1:0] ADDR  = 2'd0
) (
    input  logic                     CLOCK50M,
    input  logic                     reset,
    input  logic                     write,
    input  logic [1:0]               address,
    input  logic [17:0]              pattern_with_timestamp,
    input  logic [9:0]               counter10h,
    output logic [7:0]               pattern,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               missed,
    output logic [7:0]               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          shown;

    logic [17:0] head;
    logic [9:0]  head_ts;
    logic [7:0]  head_pat;
    logic        push_req;
    logic        push;
    logic        reject;
    logic        hit;
    logic        pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign head     = mem[rptr];
    assign head_ts  = head[17:8];
    assign head_pat = head[7:0];
    assign push_req = write && (address == ADDR);
    assign push     = push_req && !full;
    assign reject   = push_req && full;
    assign hit      = !empty && (head_ts == counter10h);
    assign pop      = !empty && (head_ts < counter10h);

    // Storage is not reset; occupancy alone defines which slots are live.
    always_ff @(posedge CLOCK50M) begin
        if (push)
            mem[wptr] <= pattern_with_timestamp;
    end

    always_ff @(posedge CLOCK50M) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            shown    <= 1'b0;
            pattern  <= 8'h00;
            missed   <= 8'h00;
            overflow <= 8'h00;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop) begin
                rptr  <= rptr + 1'b1;
                shown <= 1'b0;
            end else if (hit) begin
                shown <= 1'b1;
            end
            pattern <= hit ? head_pat : 8'h00;
            if (pop && !shown && missed != 8'hFF)
                missed <= missed + 1'b1;
            if (reject && overflow != 8'hFF)
                overflow <= overflow + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
